// File: rtl/clock_pkg.sv
// Shared definitions for the clock editor: word bit-slices, field limits, cursor codes, editor states.
// Constants only; no timing or flow-control behaviour of its own.
package clock_pkg;

    localparam int HOUR_MSB = 16;
    localparam int HOUR_LSB = 12;
    localparam int MIN_MSB  = 11;
    localparam int MIN_LSB  = 6;
    localparam int SEC_MSB  = 5;
    localparam int SEC_LSB  = 0;

    localparam int YEAR_MSB = 15;
    localparam int YEAR_LSB = 9;
    localparam int MON_MSB  = 8;
    localparam int MON_LSB  = 5;
    localparam int DAY_MSB  = 4;
    localparam int DAY_LSB  = 0;

    localparam logic [6:0] HOUR_MAX = 7'd23;
    localparam logic [6:0] MIN_MAX  = 7'd59;
    localparam logic [6:0] SEC_MAX  = 7'd59;
    localparam logic [6:0] YEAR_MAX = 7'd99;
    localparam logic [6:0] MON_MIN  = 7'd1;
    localparam logic [6:0] MON_MAX  = 7'd12;
    localparam logic [6:0] DAY_MIN  = 7'd1;
    localparam logic [6:0] DAY_MAX  = 7'd31;

    localparam logic [2:0] FLD_HOUR = 3'd0;
    localparam logic [2:0] FLD_MIN  = 3'd1;
    localparam logic [2:0] FLD_SEC  = 3'd2;
    localparam logic [2:0] FLD_YEAR = 3'd3;
    localparam logic [2:0] FLD_MON  = 3'd4;
    localparam logic [2:0] FLD_DAY  = 3'd5;

    localparam logic [15:0] DATE_RST = {7'd16, 4'd1, 5'd1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EDIT_T,
        ST_EDIT_A,
        ST_WAIT_T,
        ST_WAIT_A
    } state_t;

endpackage

// File: rtl/field_step.sv
// Wrap-around increment/decrement of one field; out-of-range values snap to the minimum when stepped.
// Purely combinational, no latency; no flow control.
module field_step #(
    parameter int W = 7
) (
    input  logic [W-1:0] value_i,
    input  logic [W-1:0] min_i,
    input  logic [W-1:0] max_i,
    input  logic         up_i,
    input  logic         down_i,
    output logic [W-1:0] value_o
);

    always_comb begin
        value_o = value_i;
        if (up_i != down_i) begin
            if (value_i < min_i || value_i > max_i) begin
                value_o = min_i;
            end else if (up_i) begin
                value_o = (value_i == max_i) ? min_i : value_i + 1'b1;
            end else begin
                value_o = (value_i == min_i) ? max_i : value_i - 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_setter.sv
// Button-driven editor for time/date/alarm words; commit strobe held until SETTING_OK or timeout.
// Outputs registered, one cycle after the button pulse; buttons are ignored while a commit is pending.
module time_setter
    import clock_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 1000,
    parameter logic [16:0] ALARM_RST   = 17'd0
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [16:0] CUR_TIME,
    input  logic [15:0] CUR_DATE,
    input  logic        BTN_EDIT,
    input  logic        BTN_ALARM,
    input  logic        BTN_NEXT,
    input  logic        BTN_UP,
    input  logic        BTN_DOWN,
    input  logic        SETTING_OK,
    output logic [16:0] SET_TIME,
    output logic [15:0] SET_DATE,
    output logic [16:0] SET_ALARM_TIME,
    output logic        SETTING,
    output logic        ALARM_SETTING,
    output logic        MODE,
    output logic        MODE_STATE,
    output logic [2:0]  FIELD,
    output logic        ERR
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t        state_q;
    logic [16:0]   time_q;
    logic [15:0]   date_q;
    logic [16:0]   alarm_q;
    logic [16:0]   alarm_store_q;
    logic          setting_q;
    logic          alarm_setting_q;
    logic          mode_q;
    logic          mode_state_q;
    logic [2:0]    field_q;
    logic          err_q;
    logic [TW-1:0] tmo_q;

    logic          is_alarm;
    logic [2:0]    last_fld;
    logic [16:0]   src_time;
    logic [16:0]   time_d;
    logic [15:0]   date_d;
    logic [6:0]    cur_val;
    logic [6:0]    lo_val;
    logic [6:0]    hi_val;
    logic [6:0]    step_val;

    // Alarm edit reuses the hour/min/sec cursor positions against the alarm copy.
    always_comb begin
        is_alarm = (state_q == ST_EDIT_A);
        last_fld = is_alarm ? FLD_SEC : FLD_DAY;
        src_time = is_alarm ? alarm_q : time_q;
        cur_val  = '0;
        lo_val   = '0;
        hi_val   = '0;
        case (field_q)
            FLD_HOUR: begin cur_val = {2'b0, src_time[HOUR_MSB:HOUR_LSB]}; hi_val = HOUR_MAX; end
            FLD_MIN:  begin cur_val = {1'b0, src_time[MIN_MSB:MIN_LSB]};   hi_val = MIN_MAX;  end
            FLD_SEC:  begin cur_val = {1'b0, src_time[SEC_MSB:SEC_LSB]};   hi_val = SEC_MAX;  end
            FLD_YEAR: begin cur_val = date_q[YEAR_MSB:YEAR_LSB];           hi_val = YEAR_MAX; end
            FLD_MON:  begin cur_val = {3'b0, date_q[MON_MSB:MON_LSB]}; lo_val = MON_MIN; hi_val = MON_MAX; end
            FLD_DAY:  begin cur_val = {2'b0, date_q[DAY_MSB:DAY_LSB]}; lo_val = DAY_MIN; hi_val = DAY_MAX; end
            default: ;
        endcase
    end

    field_step #(.W(7)) u_step (
        .value_i (cur_val),
        .min_i   (lo_val),
        .max_i   (hi_val),
        .up_i    (BTN_UP),
        .down_i  (BTN_DOWN),
        .value_o (step_val)
    );

    always_comb begin
        time_d = src_time;
        date_d = date_q;
        case (field_q)
            FLD_HOUR: time_d[HOUR_MSB:HOUR_LSB] = step_val[4:0];
            FLD_MIN:  time_d[MIN_MSB:MIN_LSB]   = step_val[5:0];
            FLD_SEC:  time_d[SEC_MSB:SEC_LSB]   = step_val[5:0];
            FLD_YEAR: date_d[YEAR_MSB:YEAR_LSB] = step_val[6:0];
            FLD_MON:  date_d[MON_MSB:MON_LSB]   = step_val[3:0];
            FLD_DAY:  date_d[DAY_MSB:DAY_LSB]   = step_val[4:0];
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q         <= ST_IDLE;
            time_q          <= '0;
            date_q          <= DATE_RST;
            alarm_q         <= ALARM_RST;
            alarm_store_q   <= ALARM_RST;
            setting_q       <= 1'b0;
            alarm_setting_q <= 1'b0;
            mode_q          <= 1'b0;
            mode_state_q    <= 1'b0;
            field_q         <= FLD_HOUR;
            err_q           <= 1'b0;
            tmo_q           <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (BTN_EDIT) begin
                        state_q <= ST_EDIT_T;
                        time_q  <= CUR_TIME;
                        date_q  <= CUR_DATE;
                        field_q <= FLD_HOUR;
                        mode_q  <= 1'b1;
                    end else if (BTN_ALARM) begin
                        state_q      <= ST_EDIT_A;
                        alarm_q      <= alarm_store_q;
                        field_q      <= FLD_HOUR;
                        mode_state_q <= 1'b1;
                    end
                end
                ST_EDIT_T, ST_EDIT_A: begin
                    if (BTN_EDIT || BTN_ALARM) begin
                        state_q      <= ST_IDLE;
                        mode_q       <= 1'b0;
                        mode_state_q <= 1'b0;
                        field_q      <= FLD_HOUR;
                        alarm_q      <= alarm_store_q;
                    end else begin
                        if (is_alarm) begin
                            alarm_q <= time_d;
                        end else begin
                            time_q <= time_d;
                            date_q <= date_d;
                        end
                        if (BTN_NEXT) begin
                            if (field_q == last_fld) begin
                                field_q <= FLD_HOUR;
                                tmo_q   <= '0;
                                if (is_alarm) begin
                                    state_q         <= ST_WAIT_A;
                                    alarm_setting_q <= 1'b1;
                                end else begin
                                    state_q   <= ST_WAIT_T;
                                    setting_q <= 1'b1;
                                end
                            end else begin
                                field_q <= field_q + 3'd1;
                            end
                        end
                    end
                end
                ST_WAIT_T, ST_WAIT_A: begin
                    if (SETTING_OK || tmo_q == TMO_LAST) begin
                        state_q         <= ST_IDLE;
                        setting_q       <= 1'b0;
                        alarm_setting_q <= 1'b0;
                        mode_q          <= 1'b0;
                        mode_state_q    <= 1'b0;
                        if (SETTING_OK) begin
                            if (state_q == ST_WAIT_A) alarm_store_q <= alarm_q;
                        end else begin
                            err_q   <= 1'b1;
                            alarm_q <= alarm_store_q;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign SET_TIME       = time_q;
    assign SET_DATE       = date_q;
    assign SET_ALARM_TIME = alarm_q;
    assign SETTING        = setting_q;
    assign ALARM_SETTING  = alarm_setting_q;
    assign MODE           = mode_q;
    assign MODE_STATE     = mode_state_q;
    assign FIELD          = field_q;
    assign ERR            = err_q;

endmodule

// File: tb/tb_time_setter.sv
// Bench for time_setter: field-array reference model checked every cycle, plus directed literal checks.
module tb_time_setter;

    localparam int T = 16;
    localparam logic [4:0] B_EDIT  = 5'b10000;
    localparam logic [4:0] B_ALARM = 5'b01000;
    localparam logic [4:0] B_NEXT  = 5'b00100;
    localparam logic [4:0] B_UP    = 5'b00010;
    localparam logic [4:0] B_DOWN  = 5'b00001;

    logic        CLK, RESETN;
    logic [16:0] CUR_TIME;
    logic [15:0] CUR_DATE;
    logic        BTN_EDIT, BTN_ALARM, BTN_NEXT, BTN_UP, BTN_DOWN, SETTING_OK;
    logic [16:0] SET_TIME, SET_ALARM_TIME;
    logic [15:0] SET_DATE;
    logic        SETTING, ALARM_SETTING, MODE, MODE_STATE, ERR;
    logic [2:0]  FIELD;

    time_setter #(.TIMEOUT_CYC(T), .ALARM_RST(17'h06000)) dut (
        .CLK(CLK), .RESETN(RESETN), .CUR_TIME(CUR_TIME), .CUR_DATE(CUR_DATE),
        .BTN_EDIT(BTN_EDIT), .BTN_ALARM(BTN_ALARM), .BTN_NEXT(BTN_NEXT),
        .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN), .SETTING_OK(SETTING_OK),
        .SET_TIME(SET_TIME), .SET_DATE(SET_DATE), .SET_ALARM_TIME(SET_ALARM_TIME),
        .SETTING(SETTING), .ALARM_SETTING(ALARM_SETTING), .MODE(MODE),
        .MODE_STATE(MODE_STATE), .FIELD(FIELD), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [16:0] pk_t(input int h, input int m, input int s);
        return 17'(h * 4096 + m * 64 + s);
    endfunction

    function automatic logic [15:0] pk_d(input int y, input int mo, input int d);
        return 16'(y * 512 + mo * 32 + d);
    endfunction

    // Reference: modes 0 idle, 1 time edit, 2 alarm edit, 3 time wait, 4 alarm wait.
    int LO[6] = '{0, 0, 0, 0, 1, 1};
    int HI[6] = '{23, 59, 59, 99, 12, 31};
    int ms, fld, wc;
    int tv[6];
    int av[3];
    int sv[3];
    bit m_err;

    function automatic int adj(input int v, input int lo, input int hi, input logic up, input logic dn);
        int n;
        if (up == dn) return v;
        if (v < lo || v > hi) return lo;
        n = hi - lo + 1;
        if (up) return (v - lo + 1) % n + lo;
        return (v - lo + n - 1) % n + lo;
    endfunction

    always @(posedge CLK) begin
        if (!RESETN) begin
            ms = 0; fld = 0; wc = 0; m_err = 0;
            tv = '{0, 0, 0, 16, 1, 1};
            sv = '{6, 0, 0};
            av = sv;
        end else begin
            m_err = 0;
            case (ms)
                0: begin
                    if (BTN_EDIT) begin
                        tv[0] = int'(CUR_TIME[16:12]); tv[1] = int'(CUR_TIME[11:6]); tv[2] = int'(CUR_TIME[5:0]);
                        tv[3] = int'(CUR_DATE[15:9]);  tv[4] = int'(CUR_DATE[8:5]);  tv[5] = int'(CUR_DATE[4:0]);
                        fld = 0; ms = 1;
                    end else if (BTN_ALARM) begin
                        av = sv; fld = 0; ms = 2;
                    end
                end
                1, 2: begin
                    if (BTN_EDIT || BTN_ALARM) begin
                        ms = 0; fld = 0;
                    end else begin
                        if (ms == 1) tv[fld] = adj(tv[fld], LO[fld], HI[fld], BTN_UP, BTN_DOWN);
                        else         av[fld] = adj(av[fld], LO[fld], HI[fld], BTN_UP, BTN_DOWN);
                        if (BTN_NEXT) begin
                            if (fld == ((ms == 1) ? 5 : 2)) begin
                                ms = ms + 2; fld = 0; wc = 0;
                            end else begin
                                fld++;
                            end
                        end
                    end
                end
                default: begin
                    if (SETTING_OK) begin
                        if (ms == 4) sv = av;
                        ms = 0;
                    end else begin
                        wc++;
                        if (wc == T) begin ms = 0; m_err = 1; end
                    end
                end
            endcase
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("SET_TIME", SET_TIME, pk_t(tv[0], tv[1], tv[2]));
            check("SET_DATE", SET_DATE, pk_d(tv[3], tv[4], tv[5]));
            check("SET_ALARM_TIME", SET_ALARM_TIME,
                  (ms == 2 || ms == 4) ? pk_t(av[0], av[1], av[2]) : pk_t(sv[0], sv[1], sv[2]));
            check("SETTING", SETTING, ms == 3);
            check("ALARM_SETTING", ALARM_SETTING, ms == 4);
            check("MODE", MODE, ms == 1 || ms == 3);
            check("MODE_STATE", MODE_STATE, ms == 2 || ms == 4);
            check("FIELD", FIELD, fld);
            check("ERR", ERR, m_err);
        end
    end

    // One cycle of button/ack inputs; returns just after the edge that consumed them.
    task automatic step(input logic [4:0] b, input logic ok);
        @(negedge CLK);
        {BTN_EDIT, BTN_ALARM, BTN_NEXT, BTN_UP, BTN_DOWN} = b;
        SETTING_OK = ok;
        @(posedge CLK);
        #1;
        {BTN_EDIT, BTN_ALARM, BTN_NEXT, BTN_UP, BTN_DOWN} = 5'b0;
        SETTING_OK = 1'b0;
    endtask

    int n_hi;
    bit got_err;

    initial begin
        RESETN = 1'b0;
        {BTN_EDIT, BTN_ALARM, BTN_NEXT, BTN_UP, BTN_DOWN} = 5'b0;
        SETTING_OK = 1'b0;
        CUR_TIME = pk_t(23, 59, 58);
        CUR_DATE = pk_d(24, 12, 31);
        repeat (2) @(posedge CLK);
        #1;
        chk_en = 1'b1;
        check("rst_date", SET_DATE, 16'h2021);
        check("rst_alarm", SET_ALARM_TIME, 17'h06000);
        check("rst_setting", SETTING, 0);
        @(negedge CLK);
        RESETN = 1'b1;

        step(B_UP, 1'b0);
        step(B_DOWN, 1'b0);
        step(B_NEXT, 1'b1);
        check("idle_field", FIELD, 0);
        check("idle_time", SET_TIME, 0);

        step(B_EDIT, 1'b0);
        check("load_time", SET_TIME, pk_t(23, 59, 58));
        check("load_mode", MODE, 1);
        step(B_UP, 1'b0);
        check("hour_wrap", SET_TIME[16:12], 0);
        step(B_NEXT, 1'b0);
        check("field_min", FIELD, 1);
        step(B_DOWN, 1'b0);
        check("min_dec", SET_TIME[11:6], 58);
        step(B_UP, 1'b0);
        check("min_inc", SET_TIME[11:6], 59);
        step(B_UP, 1'b0);
        check("min_wrap", SET_TIME[11:6], 0);
        step(B_UP | B_DOWN, 1'b0);
        check("up_down", SET_TIME[11:6], 0);
        step(B_EDIT, 1'b0);
        check("abort_mode", MODE, 0);
        check("abort_setting", SETTING, 0);

        step(B_EDIT, 1'b0);
        repeat (4) step(B_NEXT, 1'b0);
        check("field_mon", FIELD, 4);
        step(B_UP, 1'b0);
        check("mon_wrap", SET_DATE[8:5], 1);
        step(B_NEXT, 1'b0);
        step(B_UP, 1'b0);
        check("day_wrap", SET_DATE[4:0], 1);
        step(B_NEXT, 1'b0);
        check("commit_setting", SETTING, 1);
        check("commit_date", SET_DATE, pk_d(24, 1, 1));
        step(5'b0, 1'b0);
        check("held_setting", SETTING, 1);
        check("held_date", SET_DATE, pk_d(24, 1, 1));
        step(5'b0, 1'b1);
        check("ok_setting", SETTING, 0);
        check("ok_mode", MODE, 0);

        CUR_DATE = pk_d(5, 0, 0);
        step(B_EDIT, 1'b0);
        repeat (4) step(B_NEXT, 1'b0);
        step(B_DOWN, 1'b0);
        check("mon_clamp", SET_DATE[8:5], 1);
        step(B_NEXT, 1'b0);
        step(B_UP, 1'b0);
        check("day_clamp", SET_DATE[4:0], 1);
        step(B_EDIT, 1'b0);

        step(B_ALARM, 1'b0);
        check("alarm_mode_state", MODE_STATE, 1);
        step(B_UP, 1'b0);
        step(B_NEXT, 1'b0);
        repeat (30) step(B_UP, 1'b0);
        step(B_NEXT, 1'b0);
        step(B_NEXT, 1'b0);
        check("alarm_strobe", ALARM_SETTING, 1);
        step(5'b0, 1'b0);
        step(5'b0, 1'b1);
        check("alarm_stored", SET_ALARM_TIME, 17'h07780);
        check("alarm_ms_off", MODE_STATE, 0);

        step(B_ALARM, 1'b0);
        step(B_UP, 1'b0);
        check("alarm_edit_hr", SET_ALARM_TIME, pk_t(8, 30, 0));
        step(B_ALARM, 1'b0);
        check("alarm_restore", SET_ALARM_TIME, 17'h07780);

        step(B_EDIT, 1'b0);
        repeat (6) step(B_NEXT, 1'b0);
        check("tmo_setting", SETTING, 1);
        n_hi = 1;
        got_err = 1'b0;
        for (int i = 0; i < 4 * T; i++) begin
            step(5'b0, 1'b0);
            if (ERR) begin
                got_err = 1'b1;
                break;
            end
            if (SETTING) n_hi++;
        end
        check("tmo_err", got_err, 1);
        check("tmo_len", n_hi, T);
        check("tmo_mode", MODE, 0);
        step(5'b0, 1'b0);
        check("err_pulse", ERR, 0);

        step(B_EDIT, 1'b0);
        repeat (6) step(B_NEXT, 1'b0);
        check("pre_rst_setting", SETTING, 1);
        @(negedge CLK);
        RESETN = 1'b0;
        @(posedge CLK);
        #1;
        check("rst_drop_setting", SETTING, 0);
        check("rst_drop_date", SET_DATE, 16'h2021);
        @(negedge CLK);
        RESETN = 1'b1;
        step(5'b0, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
